// File: rtl/rr_decoder_driver_pkg.sv
// Shared constants for the round-robin decoder driver: FSM encodings,
// reset pointer and hold counter width.
package rr_decoder_driver_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SETUP = 2'b01;
  localparam logic [1:0] ST_GRANT = 2'b10;

  // Pointer reset to 3 so requester 0 is searched first after reset.
  localparam logic [1:0] LAST_RST = 2'd3;

  localparam int HOLD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: starts one past the last winner and
// wraps around, ending on the last winner itself.
module rr_pick (
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  logic [3:0] req_vec;
  logic [1:0] idx;

  assign req_vec = {req3, req2, req1, req0};

  // Scanning from the farthest candidate down lets the nearest asserted
  // request overwrite the others, so no early exit is needed.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req_vec[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_decoder_driver.sv
// Round-robin arbiter driving a 2-to-4 enable decoder: address is settled a
// full cycle before enable rises, and ownership is bounded by MAX_HOLD.
module rr_decoder_driver
  import rr_decoder_driver_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic done,
  output logic address0,
  output logic address1,
  output logic enable,
  output logic expired,
  output logic busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              enable_q, enable_d;
  logic              expired_q, expired_d;
  logic              busy_q, busy_d;

  logic [3:0] req_vec;
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       timeout;
  logic       release_now;

  rr_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .req2   (req2),
    .req3   (req3),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  assign req_vec     = {req3, req2, req1, req0};
  assign owner_req   = req_vec[addr_q];
  assign timeout     = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign release_now = done || !owner_req || timeout;

  always_comb begin
    // NOTE: every signal gets a default first, so no branch can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    expired_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          addr_d  = winner;
          last_d  = winner;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d    = ST_GRANT;
        hold_cnt_d = '0;
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        if (release_now) begin
          state_d   = ST_IDLE;
          expired_d = timeout && !done && owner_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    enable_d = (state_d == ST_GRANT);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments; reset is synchronous here.
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 2'b00;
      last_q     <= LAST_RST;
      hold_cnt_q <= '0;
      enable_q   <= 1'b0;
      expired_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      enable_q   <= enable_d;
      expired_q  <= expired_d;
      busy_q     <= busy_d;
    end
  end

  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign enable   = enable_q;
  assign expired  = expired_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rr_decoder_driver.sv
// Bench for rr_decoder_driver: directed scenarios plus randomized traffic,
// all checked against an ownership-level reference model.
module tb_rr_decoder_driver;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_v;
  logic       done;
  logic       address0, address1, enable, expired, busy;
  logic [3:0] dec;

  always #5 clk = ~clk;

  rr_decoder_driver #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req_v[0]),
    .req1     (req_v[1]),
    .req2     (req_v[2]),
    .req3     (req_v[3]),
    .done     (done),
    .address0 (address0),
    .address1 (address1),
    .enable   (enable),
    .expired  (expired),
    .busy     (busy)
  );

  // Behavioural stand-in for the downstream 2-to-4 enable decoder.
  always_comb dec = enable ? (4'b0001 << {address1, address0}) : 4'b0000;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the decoder, how long they have had it.
  bit m_granted, m_pending, m_exp;
  int m_age, m_last, m_addr;

  task automatic model_step();
    if (reset) begin
      m_granted = 0; m_pending = 0; m_exp = 0;
      m_age = 0; m_last = 3; m_addr = 0;
    end else begin
      m_exp = 0;
      if (m_granted) begin
        m_age++;
        if (done || !req_v[m_addr] || m_age == MAX_HOLD) begin
          m_exp     = !done && req_v[m_addr];
          m_granted = 0;
        end
      end else if (m_pending) begin
        m_pending = 0;
        m_granted = 1;
        m_age     = 0;
      end else if (req_v != 4'b0) begin
        for (int k = 1; k <= 4; k++) begin
          int idx = (m_last + k) % 4;
          if (req_v[idx]) begin
            m_addr = idx;
            break;
          end
        end
        m_last    = m_addr;
        m_pending = 1;
      end
    end
  endtask

  logic       prev_en   = 1'b0;
  logic [1:0] prev_addr = 2'b00;
  int         low_run   = 0;
  bit         seen_grant = 0;
  int         grants[$];

  task automatic tick();
    logic       rs;
    logic [4:0] exp_vec;
    logic [3:0] exp_dec;
    logic [1:0] cur_addr;
    @(posedge clk);
    rs = reset;
    model_step();
    @(negedge clk);
    cur_addr = {address1, address0};
    exp_vec  = {2'(m_addr), m_granted, m_exp, m_pending | m_granted};
    exp_dec  = m_granted ? (4'b0001 << 2'(m_addr)) : 4'b0000;
    check("model", 32'({address1, address0, enable, expired, busy}), 32'(exp_vec));
    check("decoder", 32'(dec), 32'(exp_dec));
    check("onehot", 32'($countones(dec) <= 1), 32'd1);
    if (!rs)
      check("addr_stable", 32'((cur_addr != prev_addr) && (prev_en || enable)), 32'd0);
    if (enable && !prev_en) begin
      if (seen_grant) check("gap", 32'(low_run >= 2), 32'd1);
      grants.push_back(int'(cur_addr));
      seen_grant = 1;
      low_run    = 0;
    end
    if (!enable) low_run++;
    prev_en   = enable;
    prev_addr = cur_addr;
  endtask

  task automatic wait_en(input string tag);
    int n = 0;
    while (!enable && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 32'(enable), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    int n_hi;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] flip;
    req_v = 4'b0;
    done  = 1'b0;

    // Reset, then a single request on req2.
    do_reset(2);
    check("rst_state", 32'({address1, address0, enable, expired, busy}), 32'd0);
    req_v = 4'b0100;
    tick();
    check("s1_setup_addr", 32'({address1, address0}), 32'd2);
    check("s1_setup_en", 32'(enable), 32'd0);
    tick();
    check("s1_grant_dec", 32'(dec), 32'b0100);
    req_v = 4'b0;
    repeat (3) tick();

    // Rotation with all four requests held, done pulsed in each grant.
    do_reset(1);
    grants.delete();
    seen_grant = 0;
    req_v = 4'hf;
    for (int i = 0; i < 5; i++) begin
      wait_en("rot");
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    req_v = 4'b0;
    check("rot_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      check("rot_order", 32'(grants[i]), 32'(exp_order[i]));
    repeat (2) tick();

    // Timeout: req1 held alone, no done.
    do_reset(1);
    req_v = 4'b0010;
    wait_en("to");
    n_hi = 0;
    while (enable && n_hi < 20) begin
      n_hi++;
      tick();
    end
    check("to_len", 32'(n_hi), 32'(MAX_HOLD));
    check("to_expired", 32'(expired), 32'd1);
    tick();
    check("to_expired_pulse", 32'(expired), 32'd0);
    wait_en("to_regrant");
    check("to_regrant_addr", 32'({address1, address0}), 32'd1);

    // done on the timeout cycle is a normal release.
    repeat (MAX_HOLD - 1) tick();
    check("sim_still_en", 32'(enable), 32'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("sim_release", 32'(enable), 32'd0);
    check("sim_expired", 32'(expired), 32'd0);

    // Owner dropping its request releases without done.
    wait_en("drop");
    tick();
    req_v = 4'b0;
    tick();
    check("drop_release", 32'(enable), 32'd0);
    check("drop_expired", 32'(expired), 32'd0);
    repeat (2) tick();

    // Reset in the second grant cycle; afterwards req0 beats req3.
    req_v = 4'b0001;
    wait_en("mid");
    tick();
    check("mid_second_grant", 32'(enable), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst", 32'({address1, address0, enable, busy}), 32'd0);
    req_v = 4'b1001;
    tick();
    check("mid_pick_addr", 32'({address1, address0}), 32'd0);
    check("mid_pick_busy", 32'(busy), 32'd1);
    req_v = 4'b0;
    repeat (3) tick();

    // Randomized traffic with sticky requests and occasional done/reset.
    for (int c = 0; c < 500; c++) begin
      flip  = 4'($urandom) & 4'($urandom);
      req_v = req_v ^ flip;
      done  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0;
    done  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
